// File: rtl/fx_mul_arbiter_if.sv
// fx_mul_arbiter_if: requester and multiplier bus bundle for fx_mul_arbiter
//  req_valid/req_ready/req_a/req_b  requester issue handshake, lane i at [i*WIDTH +: WIDTH]
//  rsp_valid/rsp_result             one-hot product return, no backpressure
//  mul_*                            start/done link to the shared multiplier
interface fx_mul_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      rsp_result, mul_a, mul_b, mul_result;
  logic                  mul_rst_n, mul_start, mul_done;
  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_done,
    output req_ready, rsp_valid, rsp_result, mul_rst_n, mul_start, mul_a, mul_b
  );
  modport master (
    output req_valid, req_a, req_b, mul_result, mul_done,
    input  req_ready, rsp_valid, rsp_result, mul_rst_n, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/fx_mul_arbiter.sv
// fx_mul_arbiter: round-robin sharing of one pipelined fixed-point multiplier among NREQ requesters
//  clk, rst       clock and synchronous active-high reset
//  bus            fx_mul_arbiter_if.slave: requester handshake, response return, multiplier link
//  o_busy         ops accepted but not yet returned
//  o_err_orphan   sticky: multiplier done arrived with nothing outstanding
module fx_mul_arbiter #(
  parameter int WIDTH        = 32,
  parameter int QINT         = 16,
  parameter int NREQ         = 4,
  parameter int MUL_LATENCY  = 2,
  parameter int MAX_INFLIGHT = MUL_LATENCY + 3
) (
  input  logic            clk,
  input  logic            rst,
  fx_mul_arbiter_if.slave bus,
  output logic            o_busy,
  output logic            o_err_orphan
);
  localparam int TW = $clog2(NREQ);
  localparam int FW = MAX_INFLIGHT > 1 ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  if (NREQ < 2 || QINT >= WIDTH) begin : g_cfg
    $error("fx_mul_arbiter: requires NREQ >= 2 and QINT < WIDTH");
  end
  logic [TW-1:0]    r_ptr, w_idx;
  logic [TW-1:0]    w_ord [NREQ];
  logic [TW-1:0]    r_tag [MAX_INFLIGHT];
  logic [FW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_inflight;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_start, r_err, w_found, w_acc, w_pop;
  function automatic logic [FW-1:0] nxt(input logic [FW-1:0] p);
    return p == FW'(MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
  endfunction
  for (genvar g = 0; g < NREQ; g++) begin : g_ord
    assign w_ord[g] = TW'((int'(r_ptr) + g) % NREQ);
  end
  // Scan from the farthest slot back to ptr so the first valid in rotation order wins
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[w_ord[k]]) begin
        w_idx   = w_ord[k];
        w_found = 1'b1;
      end
    end
  end
  // The tag FIFO holds exactly the inflight ops, so its occupancy is r_inflight
  assign w_acc          = !rst && w_found && r_inflight < CW'(MAX_INFLIGHT);
  assign w_pop          = !rst && bus.mul_done && r_inflight != '0;
  assign bus.req_ready  = w_acc ? NREQ'(1) << w_idx : '0;
  assign bus.rsp_valid  = w_pop ? NREQ'(1) << r_tag[r_rp] : '0;
  assign bus.rsp_result = bus.mul_result;
  assign bus.mul_rst_n  = !rst;
  assign bus.mul_start  = r_start && !rst;
  assign bus.mul_a      = r_a;
  assign bus.mul_b      = r_b;
  assign o_busy         = !rst && r_inflight != '0;
  assign o_err_orphan   = r_err && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_inflight <= '0;
      r_start    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_err      <= 1'b0;
    end else begin
      r_start    <= w_acc;
      r_inflight <= r_inflight + CW'(w_acc) - CW'(w_pop);
      if (w_acc) begin
        r_a   <= bus.req_a[w_idx*WIDTH +: WIDTH];
        r_b   <= bus.req_b[w_idx*WIDTH +: WIDTH];
        r_wp  <= nxt(r_wp);
        r_ptr <= w_idx == TW'(NREQ - 1) ? '0 : w_idx + 1'b1;
      end
      if (w_pop) r_rp <= nxt(r_rp);
      if (bus.mul_done && r_inflight == '0) r_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) r_tag[r_wp] <= w_idx;
  end
endmodule

// File: tb/tb_fx_mul_arbiter.sv
// tb_fx_mul_arbiter: randomized scoreboard bench with an attached fixed-point multiplier model
module tb_fx_mul_arbiter;
  localparam int W = 32, QI = 16, QF = W - QI, N = 4, L = 2, MAXI = L + 3;
  logic clk = 1'b0, rst = 1'b1, inj = 1'b0;
  logic o_busy, o_err;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  fx_mul_arbiter_if #(.WIDTH(W), .NREQ(N)) bus();
  fx_mul_arbiter #(.WIDTH(W), .QINT(QI), .NREQ(N), .MUL_LATENCY(L), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_busy(o_busy), .o_err_orphan(o_err)
  );
  function automatic logic [W-1:0] fxp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = 64'($signed(a)) * 64'($signed(b));
    return p[QF +: W];
  endfunction
  logic [L+1:0] sv = '0;
  logic [W-1:0] sp [L+2];
  always @(posedge clk) begin
    if (!bus.mul_rst_n) sv <= '0;
    else begin
      sv    <= {sv[L:0], bus.mul_start};
      sp[0] <= fxp(bus.mul_a, bus.mul_b);
      for (int k = 1; k < L + 2; k++) sp[k] <= sp[k-1];
    end
  end
  assign bus.mul_done   = sv[L+1] | inj;
  assign bus.mul_result = sp[L+1];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask
  typedef struct { int tag; logic [W-1:0] res; int due; } exp_t;
  exp_t q[$];
  exp_t e;
  int m_ptr = 0, m_infl = 0, g = 0;
  bit m_err = 0, exp_st = 0, prev_rst = 0;
  logic [W-1:0] ea, eb;
  logic [N-1:0] eg;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_outputs", {bus.req_ready, bus.rsp_valid, bus.mul_start, o_busy, o_err, bus.mul_rst_n}, 0);
      q.delete();
      m_ptr = 0; m_infl = 0; m_err = 0; exp_st = 0; prev_rst = 1;
    end else begin
      if (prev_rst) chk("rst_operands", {bus.mul_a, bus.mul_b}, 0);
      prev_rst = 0;
      chk("mul_start", bus.mul_start, exp_st);
      if (exp_st) chk("mul_operands", {bus.mul_a, bus.mul_b}, {ea, eb});
      chk("busy", o_busy, m_infl != 0);
      chk("err_orphan", o_err, m_err);
      eg = '0;
      if (m_infl < MAXI)
        for (int k = 0; k < N; k++)
          if (eg == 0 && bus.req_valid[(m_ptr + k) % N]) begin
            g = (m_ptr + k) % N;
            eg[g] = 1'b1;
          end
      chk("req_ready", bus.req_ready, eg);
      if (bus.mul_done) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_infl--;
          chk("rsp_valid", bus.rsp_valid, 1 << e.tag);
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_latency", cyc, e.due);
        end else begin
          chk("orphan_rsp", bus.rsp_valid, 0);
          m_err = 1;
        end
      end else begin
        chk("rsp_idle", bus.rsp_valid, 0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL rsp_timeout cycle %0d: got no response, required tag %0d at cycle %0d", cyc, e.tag, e.due);
        end
      end
      exp_st = eg != 0;
      if (exp_st) begin
        ea = bus.req_a[g*W +: W];
        eb = bus.req_b[g*W +: W];
        q.push_back('{g, fxp(ea, eb), cyc + 3 + L});
        m_ptr = (g + 1) % N;
        m_infl++;
      end
    end
  end
  task automatic step(input logic [N-1:0] v);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = $urandom;
      bus.req_b[i*W +: W] = $urandom;
    end
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    step(0); step(0); rst = 1'b0;
    step(4'b0001);
    bus.req_a[W-1:0] = 32'h0001_8000;
    bus.req_b[W-1:0] = 32'h0002_0000;
    repeat (8) step(0);
    repeat (2) step(4'b1001);
    step(4'b1111);
    repeat (8) step(0);
    step(0); rst = 1'b1; step(0); rst = 1'b0;
    repeat (8) step(4'b1111);
    repeat (10) step(0);
    repeat (3) step(N'($urandom_range(1, 15)));
    step(0); rst = 1'b1; step(0); rst = 1'b0;
    repeat (8) step(0);
    step(4'b0100);
    repeat (8) step(0);
    step(0); inj = 1'b1; step(0); inj = 1'b0;
    repeat (5) step(0);
    step(0); rst = 1'b1; step(0); rst = 1'b0;
    step(0);
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom_range(0, 15)));
      rst = $urandom_range(0, 99) == 0;
    end
    rst = 1'b0;
    repeat (15) step(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
